pkt_fifo: RTL
=============

// Module: pkt_fifo
// PURPOSE
//  Packet FIFO between correlator packet generator and the bytepipe register block.
//  Accepts whole fixed-size packets in parallel, presents them one byte at a time.
//  Packets are popped via the register block's fifo-read address; bytes leave oldest first.
//  Producer cannot stall: a packet arriving while full is dropped and flagged.
// PARAMETERS
//  DEPTH      10  capacity in packets, >=2, need not be a power of 2
//  PKT_BYTES  8   bytes per packet, >=2
// PORTS
//  i_clk        in   1               clock
//  i_rst_n      in   1               reset, asynchronous, active-low
//  i_cg         in   1               clock-gate enable; low => all state holds
//  i_pkt_data   in   8*PKT_BYTES     packet; byte0=[7:0] is sent first
//  i_pkt_valid  in   1               push request, 1-cycle strobe per packet
//  i_pop        in   1               consume current head byte
//  i_flush      in   1               discard all contents
//  o_data       out  8               head byte, combinational from storage
//  o_empty      out  1               no packet stored (valid = !o_empty)
//  o_full       out  1               DEPTH packets stored
//  o_nPkts      out  $clog2(DEPTH+1) packets stored, including partially read head
//  o_overflow   out  1               registered 1-cycle pulse: a push was dropped
// BEHAVIOUR
//  - Reset: wrPtr=rdPtr=byteIdx=nPkts=0; o_empty=1, o_full=0, o_nPkts=0, o_overflow=0,
//    o_data=byte0 of slot 0 (undefined contents, no reset on storage).
//  - Only updates when i_cg=1. Priority: flush > push/pop.
//  - Push: i_pkt_valid && !o_full => store in slot wrPtr, wrPtr wraps DEPTH-1->0, nPkts+1.
//    Visible on o_data/o_empty the next cycle (1-cycle latency, no bypass).
//  - Push while full (after this cycle's pop) => dropped, storage untouched, o_overflow=1 next cycle.
//    A pop of the last head byte in the same cycle frees a slot: push is accepted.
//  - Pop: i_pop && !o_empty => byteIdx+1; at byteIdx==PKT_BYTES-1: byteIdx=0,
//    rdPtr wraps DEPTH-1->0, nPkts-1. Pop while empty ignored, no error.
//  - Push and last-byte pop same cycle => nPkts unchanged, both pointers advance.
//  - Flush: pointers, byteIdx, nPkts cleared; same-cycle push and pop discarded, no overflow.
//  - o_data = slot[rdPtr] byte byteIdx; stable while not popped; sink samples before pop.
//  - o_empty = (nPkts==0); o_full = (nPkts==DEPTH); both decoded from the registered count.
// CONFIGURATION
//  PKT_FIFO_DROPCOUNT_EN defined: extra port o_nDropped out 8, registered saturating
//    count of dropped pushes; reset 0, cleared by i_flush, holds at 255.
//  Not defined: port absent, no counter logic; o_overflow behaviour identical.
// STRUCTURE
//  - corr_pkg: PKT_BYTES default, BYTE_W=8, pkt_t = logic [8*PKT_BYTES-1:0].
//    The pkt_fifo instance in the correlator top uses the same DEPTH as the
//    register block's PKTFIFO_DEPTH, so that register reports the true capacity.
//  - One sub-module: pkt_fifo_mem, DEPTH x pkt_t array, 1 write port,
//    1 async read port with byte-select mux; control, pointers and count stay in pkt_fifo.
// TESTING
//  1 Reset, then push packet 0x0807060504030201 -> next cycle o_empty=0, o_nPkts=1,
//    o_data=0x01; 8 pops -> 01..08 in order, then o_empty=1, o_nPkts=0.
//  2 Push 10 packets -> o_full=1; 11th push -> dropped, o_overflow one-cycle pulse,
//    o_nPkts=10; drain 80 bytes in push order, nothing from the dropped packet.
//  3 Full, pop byte 7 of head while pushing -> push accepted, o_nPkts stays 10, no overflow.
//  4 Wrap: 25 push/drain cycles of distinct packets -> rdPtr/wrPtr wrap past slot 9,
//    byte stream exact; pop while empty -> no state change.
//  5 3 packets stored, mid-packet (byteIdx=3) assert i_flush with push -> o_empty=1,
//    o_nPkts=0; next push reads from byte 0. With PKT_FIFO_DROPCOUNT_EN, 300 drops ->
//    o_nDropped=255; flush -> 0.
//  6 Assert i_rst_n low mid-drain asynchronously -> outputs at reset values immediately;
//    i_cg=0 with push/pop active -> no change.

Source files
------------

// File: rtl/corr_pkg.sv
// corr_pkg: shared correlator constants and packet type.
//   PKT_BYTES     default bytes per packet
//   BYTE_W        width of one byte lane
//   PKTFIFO_DEPTH packet FIFO capacity; the register block reports this value
//   pkt_t         one whole packet, byte0 in the low lane
package corr_pkg;
    localparam int PKT_BYTES     = 8;
    localparam int BYTE_W        = 8;
    localparam int PKTFIFO_DEPTH = 10;
    typedef logic [BYTE_W*PKT_BYTES-1:0] pkt_t;
endpackage

// File: rtl/pkt_fifo_mem.sv
// pkt_fifo_mem: DEPTH x packet storage, one write port, one async byte-select read port.
//   i_clk     in   clock
//   i_we      in   write enable (already qualified by clock gate and flush)
//   i_wrAddr  in   slot to write
//   i_wrData  in   packet to store
//   i_rdAddr  in   slot to read
//   i_byteSel in   byte lane of the read slot
//   o_rdData  out  selected byte, combinational
module pkt_fifo_mem import corr_pkg::*; #(
    parameter int DEPTH = PKTFIFO_DEPTH,
    parameter int NBYTES = corr_pkg::PKT_BYTES,
    parameter int AW = $clog2(DEPTH),
    parameter int BW = $clog2(NBYTES)
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [AW-1:0]            i_wrAddr,
    input  logic [BYTE_W*NBYTES-1:0] i_wrData,
    input  logic [AW-1:0]            i_rdAddr,
    input  logic [BW-1:0]            i_byteSel,
    output logic [BYTE_W-1:0]        o_rdData
);
    logic [BYTE_W*NBYTES-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) mem[i_wrAddr] <= i_wrData;
    end

    assign o_rdData = mem[i_rdAddr][i_byteSel*BYTE_W +: BYTE_W];
endmodule

// File: rtl/pkt_fifo.sv
// pkt_fifo: packet-in, byte-out FIFO; drops (and flags) pushes that find it full.
//   i_clk, i_rst_n  clock, async active-low reset
//   i_cg            clock-gate enable; low holds all state
//   i_pkt_data      packet, byte0 = [7:0] leaves first
//   i_pkt_valid     push strobe
//   i_pop           consume head byte
//   i_flush         discard everything (beats push/pop)
//   o_data          head byte, combinational from storage
//   o_empty/o_full  decoded from the registered packet count
//   o_nPkts         packets stored, partially read head included
//   o_overflow      registered pulse: a push was dropped
//   o_nDropped      saturating drop count, only with PKT_FIFO_DROPCOUNT_EN defined
module pkt_fifo import corr_pkg::*; #(
    parameter int DEPTH = PKTFIFO_DEPTH,
    parameter int PKT_BYTES = corr_pkg::PKT_BYTES,
    localparam int AW = $clog2(DEPTH),
    localparam int BW = $clog2(PKT_BYTES),
    localparam int CW = $clog2(DEPTH+1)
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_cg,
    input  logic [BYTE_W*PKT_BYTES-1:0] i_pkt_data,
    input  logic                        i_pkt_valid,
    input  logic                        i_pop,
    input  logic                        i_flush,
    output logic [BYTE_W-1:0]           o_data,
    output logic                        o_empty,
    output logic                        o_full,
    output logic [CW-1:0]               o_nPkts,
    output logic                        o_overflow
`ifdef PKT_FIFO_DROPCOUNT_EN
   ,output logic [7:0]                  o_nDropped
`endif
);
    logic [AW-1:0] wrPtr, rdPtr;
    logic [BW-1:0] byteIdx;
    logic [CW-1:0] nPkts;
    logic doPop, popPkt, doPush, drop;

    assign o_empty = nPkts == '0;
    assign o_full  = nPkts == CW'(DEPTH);
    assign o_nPkts = nPkts;
    assign doPop   = i_pop && !o_empty;
    assign popPkt  = doPop && byteIdx == BW'(PKT_BYTES-1);
    // Finishing the head packet this cycle frees its slot for a same-cycle push.
    assign doPush  = i_pkt_valid && (!o_full || popPkt);
    assign drop    = i_pkt_valid && !doPush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            byteIdx    <= '0;
            nPkts      <= '0;
            o_overflow <= 1'b0;
        end else if (i_cg) begin
            if (i_flush) begin
                wrPtr      <= '0;
                rdPtr      <= '0;
                byteIdx    <= '0;
                nPkts      <= '0;
                o_overflow <= 1'b0;
            end else begin
                if (doPush) wrPtr <= wrPtr == AW'(DEPTH-1) ? '0 : wrPtr + 1'b1;
                if (popPkt) rdPtr <= rdPtr == AW'(DEPTH-1) ? '0 : rdPtr + 1'b1;
                if (doPop) byteIdx <= popPkt ? '0 : byteIdx + 1'b1;
                nPkts      <= nPkts + CW'(doPush) - CW'(popPkt);
                o_overflow <= drop;
            end
        end
    end

`ifdef PKT_FIFO_DROPCOUNT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_nDropped <= '0;
        else if (i_cg) o_nDropped <= i_flush ? '0 : (drop && o_nDropped != 8'hFF) ? o_nDropped + 1'b1 : o_nDropped;
    end
`endif

    pkt_fifo_mem #(.DEPTH(DEPTH), .NBYTES(PKT_BYTES)) uMem (
        .i_clk    (i_clk),
        .i_we     (i_cg && !i_flush && doPush),
        .i_wrAddr (wrPtr),
        .i_wrData (i_pkt_data),
        .i_rdAddr (rdPtr),
        .i_byteSel(byteIdx),
        .o_rdData (o_data)
    );
endmodule
